tcp_mem_responder: RTL and testbench
====================================

# tcp_mem_responder

On-chip memory responder for one TCP channel's DDR datamover interface. It sits where the external memory controller would be: it accepts the network stack's read and write memory commands, stores and returns 512-bit data beats in a dual-port BRAM, and returns a datamover-style status per command. It lets the TCP RX/TX buffering path run without DDR, for bring-up and throughput measurement, and serves one channel of the `NUM_TCP_CHANNELS` arrays.

## Interface
- `MEM_DEPTH`, 4096: BRAM depth in 512-bit words; power of two.
- `AW`, `$clog2(MEM_DEPTH)`: word-address width (derived).

- `aclk` in 1: single clock for all logic.
- `sys_reset` in 1: reset, synchronous, active-high.
- `s_axis_write_cmd_valid/ready` in/out 1: write command handshake.
- `s_axis_write_cmd_address` in 64: byte address.
- `s_axis_write_cmd_length` in 32: byte count.
- `s_axis_write_data_valid/ready/last` in/out/in 1: write data stream.
- `s_axis_write_data_data` in 512; `s_axis_write_data_keep` in 64: data and byte enables.
- `m_axis_write_sts_valid/ready` out/in 1; `m_axis_write_sts_data` out 8: write status.
- `s_axis_read_cmd_valid/ready` in/out 1; `s_axis_read_cmd_address` in 64; `s_axis_read_cmd_length` in 32: read command.
- `m_axis_read_data_valid/ready/last` out/in/out 1; `m_axis_read_data_data` out 512; `m_axis_read_data_keep` out 64: read data stream.
- `m_axis_read_sts_valid/ready` out/in 1; `m_axis_read_sts_data` out 8: read status.

## Operation
- Word index is `address[AW+5:6]`. `address[5:0]` is ignored, because commands are 64-byte aligned. The index increments by 1 per beat and wraps modulo `MEM_DEPTH`.
- Beat count is `beats = (length + 63) >> 6`, computed in 27 bits.
- Status encoding:
  - `sts[7]` = okay.
  - `sts[0]` = error.
  - `sts[6:1]` = 0.
  - Success is `8'h80`; error is `8'h01`.
- Write and read FSMs are independent. There is no ordering between a read and a write.
- Write FSM:
  - `W_IDLE`: `cmd_ready=1`. On handshake, latch index and beats. If `length==0`, go to `W_STS` with error; otherwise go to `W_DATA`.
  - `W_DATA`: `data_ready=1`. Each handshake writes the beat with `keep` as byte enables and decrements the remaining count.
    - `last` before the final beat: write that beat, go to `W_STS`, error=1.
    - Final beat with `last=1`: go to `W_STS`, error=0.
    - Final beat with `last=0`: go to `W_DRAIN`, error=1.
  - `W_DRAIN`: `data_ready=1`. Discard beats with no memory write until a beat with `last=1`, then go to `W_STS`.
  - `W_STS`: `sts_valid=1`, data held stable until `sts_ready`, then go to `W_IDLE`.
- Read FSM:
  - `R_IDLE`: `cmd_ready=1`. `length==0` goes to `R_STS` with error and emits no data.
  - `R_DATA`: issue one BRAM read per cycle while the 2-entry output skid FIFO has room, or will have room that cycle.
    - Non-final beats: `keep` all-ones.
    - Final beat: `last=1`; `keep = (length[5:0]==0) ? all-ones : (64'h1 << length[5:0]) - 1`.
    - After the final beat's output handshake, go to `R_STS`.
  - `R_STS`: `sts_valid=1` with `8'h80`, or `8'h01` for a length-0 command. Stay until `sts_ready`, then go to `R_IDLE`.
- A write and a read to the same word in the same cycle: the read returns old data (read-first).
- `sys_reset` mid-operation:
  - Both FSMs go to IDLE and the skid FIFO is flushed.
  - Partially transferred beats are abandoned and no status is issued for them.
  - BRAM contents are retained.

## Timing
- Reset values of outputs:
  - Both `cmd_ready` = 1.
  - Write `data_ready` = 0.
  - All `*_valid` = 0.
  - `last` = 0; `keep` = 0; `data` = 0.
  - `sts_data` = 0.
- Write path:
  - Data is accepted the cycle after the command handshake.
  - A written beat is visible to the read port from the next cycle.
  - `sts_valid` rises the cycle after the terminating data handshake.
- Read path:
  - Command handshake at cycle T: first `data_valid` at T+2.
  - Throughput is 1 beat/cycle while `ready=1`.
  - Under backpressure, valid, data, keep and last are held stable; no beat is lost or duplicated.
  - `sts_valid` rises the cycle after the final data handshake.
- A new command is accepted the cycle after the status handshake. Command acceptance rate is at most one command per (beats + 3) cycles.

## Test plan
- Write command addr `0x0`, length 128, two beats (second with `last`) -> `write_sts` is `8'h80` one cycle later. Then a read command addr `0x0`, length 128 -> data at T+2 and T+3, matching the written beats; `keep` all-ones; `last` on the second beat; `read_sts` is `8'h80`.
- Read command length 100 -> 2 beats; final `keep` = `64'h0000_000F_FFFF_FFFF`.
- Write command length 192 with `last` on beat 2 -> `sts` = `8'h01`; beat 3 is never written. Write command length 64 with `last=0` on beat 1 and `last` on beat 3 -> beats 2 and 3 are discarded; `sts` = `8'h01`.
- Address `(MEM_DEPTH-1)*64`, length 128 -> second beat wraps to word 0, verified on readback.
- Random `m_axis_read_data_ready` toggling over a 64-beat read -> all 64 beats delivered in order, data stable while stalled.
- `sys_reset` asserted mid-read (beat 5 of 16) -> `valid` is 0 the next cycle. A following fresh command completes normally and previously written data persists.

Source files
------------

// File: rtl/tcp_mem_responder_if.sv
// tcp_mem_responder_if: datamover command, data and status
// bundle for one TCP channel's memory port.
interface tcp_mem_responder_if;
  logic         s_axis_write_cmd_valid;
  logic         s_axis_write_cmd_ready;
  logic [63:0]  s_axis_write_cmd_address;
  logic [31:0]  s_axis_write_cmd_length;

  logic         s_axis_write_data_valid;
  logic         s_axis_write_data_ready;
  logic         s_axis_write_data_last;
  logic [511:0] s_axis_write_data_data;
  logic [63:0]  s_axis_write_data_keep;

  logic         m_axis_write_sts_valid;
  logic         m_axis_write_sts_ready;
  logic [7:0]   m_axis_write_sts_data;

  logic         s_axis_read_cmd_valid;
  logic         s_axis_read_cmd_ready;
  logic [63:0]  s_axis_read_cmd_address;
  logic [31:0]  s_axis_read_cmd_length;

  logic         m_axis_read_data_valid;
  logic         m_axis_read_data_ready;
  logic         m_axis_read_data_last;
  logic [511:0] m_axis_read_data_data;
  logic [63:0]  m_axis_read_data_keep;

  logic         m_axis_read_sts_valid;
  logic         m_axis_read_sts_ready;
  logic [7:0]   m_axis_read_sts_data;

  modport slave (
    input  s_axis_write_cmd_valid,
    output s_axis_write_cmd_ready,
    input  s_axis_write_cmd_address,
    input  s_axis_write_cmd_length,
    input  s_axis_write_data_valid,
    output s_axis_write_data_ready,
    input  s_axis_write_data_last,
    input  s_axis_write_data_data,
    input  s_axis_write_data_keep,
    output m_axis_write_sts_valid,
    input  m_axis_write_sts_ready,
    output m_axis_write_sts_data,
    input  s_axis_read_cmd_valid,
    output s_axis_read_cmd_ready,
    input  s_axis_read_cmd_address,
    input  s_axis_read_cmd_length,
    output m_axis_read_data_valid,
    input  m_axis_read_data_ready,
    output m_axis_read_data_last,
    output m_axis_read_data_data,
    output m_axis_read_data_keep,
    output m_axis_read_sts_valid,
    input  m_axis_read_sts_ready,
    output m_axis_read_sts_data
  );

  modport master (
    output s_axis_write_cmd_valid,
    input  s_axis_write_cmd_ready,
    output s_axis_write_cmd_address,
    output s_axis_write_cmd_length,
    output s_axis_write_data_valid,
    input  s_axis_write_data_ready,
    output s_axis_write_data_last,
    output s_axis_write_data_data,
    output s_axis_write_data_keep,
    input  m_axis_write_sts_valid,
    output m_axis_write_sts_ready,
    input  m_axis_write_sts_data,
    output s_axis_read_cmd_valid,
    input  s_axis_read_cmd_ready,
    output s_axis_read_cmd_address,
    output s_axis_read_cmd_length,
    input  m_axis_read_data_valid,
    output m_axis_read_data_ready,
    input  m_axis_read_data_last,
    input  m_axis_read_data_data,
    input  m_axis_read_data_keep,
    input  m_axis_read_sts_valid,
    output m_axis_read_sts_ready,
    input  m_axis_read_sts_data
  );
endinterface

// File: rtl/tcp_mem_responder.sv
// tcp_mem_responder: BRAM-backed stand-in for the DDR datamover
// of one TCP channel; independent write and read engines.
module tcp_mem_responder #(
  parameter int MEM_DEPTH = 4096,
  parameter int AW = $clog2(MEM_DEPTH)
) (
  input logic aclk,
  input logic sys_reset,
  tcp_mem_responder_if.slave bus
);

  localparam logic [63:0] KEEP_ALL = '1;
  localparam logic [7:0] STS_OK = 8'h80;
  localparam logic [7:0] STS_ERR = 8'h01;

  // Beats = ceil(length / 64) without a 33-bit intermediate.
  function automatic logic [26:0] f_beats(
    input logic [31:0] len
  );
    return {1'b0, len[31:6]} +
      {26'd0, |len[5:0]};
  endfunction

  logic [511:0] r_mem [MEM_DEPTH];
  logic [511:0] r_bram_q;

  // ---------------- write engine ----------------
  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_DRAIN, W_STS
  } w_st_e;

  w_st_e r_w_st;
  w_st_e w_w_nxt;
  logic [AW-1:0] r_w_idx;
  logic [26:0] r_w_rem;
  logic r_w_err;

  logic w_wc_hs;
  logic w_wd_hs;
  logic w_ws_hs;
  logic w_wlen_z;
  logic w_w_fin;
  logic w_w_last;
  logic w_we;

  assign w_wc_hs = bus.s_axis_write_cmd_valid &
    (r_w_st == W_IDLE);
  assign w_wd_hs = bus.s_axis_write_data_valid &
    ((r_w_st == W_DATA) || (r_w_st == W_DRAIN));
  assign w_ws_hs = bus.m_axis_write_sts_ready &
    (r_w_st == W_STS);
  assign w_wlen_z = (bus.s_axis_write_cmd_length == 32'd0);
  assign w_w_fin = (r_w_rem == 27'd1);
  assign w_w_last = bus.s_axis_write_data_last;
  assign w_we = w_wd_hs & (r_w_st == W_DATA);

  // Write state register.
  always_ff @(posedge aclk) begin
    if (sys_reset) r_w_st <= W_IDLE;
    else r_w_st <= w_w_nxt;
  end

  // Write next state: early last or missing last both end in error.
  always_comb begin
    w_w_nxt = r_w_st;
    unique case (r_w_st)
      W_IDLE: begin
        if (w_wc_hs)
          w_w_nxt = w_wlen_z ? W_STS : W_DATA;
      end
      W_DATA: begin
        if (w_wd_hs) begin
          if (w_w_fin && !w_w_last)
            w_w_nxt = W_DRAIN;
          else if (w_w_fin || w_w_last)
            w_w_nxt = W_STS;
        end
      end
      W_DRAIN: begin
        if (w_wd_hs && w_w_last)
          w_w_nxt = W_STS;
      end
      W_STS: begin
        if (w_ws_hs) w_w_nxt = W_IDLE;
      end
      default: w_w_nxt = W_IDLE;
    endcase
  end

  // Write outputs decoded from state.
  always_comb begin
    bus.s_axis_write_cmd_ready = (r_w_st == W_IDLE);
    bus.s_axis_write_data_ready =
      (r_w_st == W_DATA) || (r_w_st == W_DRAIN);
    bus.m_axis_write_sts_valid = (r_w_st == W_STS);
    bus.m_axis_write_sts_data = 8'h00;
    if (r_w_st == W_STS)
      bus.m_axis_write_sts_data =
        r_w_err ? STS_ERR : STS_OK;
  end

  // Write address, remaining count and error flag.
  always_ff @(posedge aclk) begin
    if (sys_reset) begin
      r_w_idx <= '0;
      r_w_rem <= '0;
      r_w_err <= 1'b0;
    end else if (w_wc_hs) begin
      r_w_idx <= bus.s_axis_write_cmd_address[AW+5:6];
      r_w_rem <= f_beats(bus.s_axis_write_cmd_length);
      r_w_err <= w_wlen_z;
    end else if (w_we) begin
      r_w_idx <= r_w_idx + AW'(1);
      r_w_rem <= r_w_rem - 27'd1;
      if (w_w_fin != w_w_last) r_w_err <= 1'b1;
    end
  end

  // ---------------- read engine ----------------
  typedef enum logic [1:0] {
    R_IDLE, R_DATA, R_STS
  } r_st_e;

  r_st_e r_r_st;
  r_st_e w_r_nxt;
  logic [AW-1:0] r_r_idx;
  logic [26:0] r_r_iss;
  logic [5:0] r_r_len6;
  logic r_r_err;
  logic r_p_vld;
  logic r_p_last;

  logic [511:0] r_f_data [2];
  logic r_f_last [2];
  logic r_f_wp;
  logic r_f_rp;
  logic [1:0] r_f_cnt;

  logic w_rc_hs;
  logic w_rs_hs;
  logic w_rlen_z;
  logic w_f_empty;
  logic w_o_vld;
  logic w_o_last;
  logic [511:0] w_o_data;
  logic w_pop;
  logic w_fpop;
  logic w_push;
  logic [2:0] w_occ;
  logic w_room;
  logic w_issue;
  logic [63:0] w_tail_keep;

  assign w_rc_hs = bus.s_axis_read_cmd_valid &
    (r_r_st == R_IDLE);
  assign w_rs_hs = bus.m_axis_read_sts_ready &
    (r_r_st == R_STS);
  assign w_rlen_z = (bus.s_axis_read_cmd_length == 32'd0);

  // The BRAM output register feeds the port directly when the
  // skid FIFO is empty, giving a two-cycle command-to-data path.
  assign w_f_empty = (r_f_cnt == 2'd0);
  assign w_o_vld = !w_f_empty || r_p_vld;
  assign w_o_data = w_f_empty ? r_bram_q : r_f_data[r_f_rp];
  assign w_o_last = w_f_empty ? r_p_last : r_f_last[r_f_rp];
  assign w_pop = w_o_vld & bus.m_axis_read_data_ready;
  assign w_fpop = w_pop & !w_f_empty;
  assign w_push = r_p_vld &
    !(w_f_empty & bus.m_axis_read_data_ready);

  // Beats held or in flight must fit the FIFO after this cycle.
  assign w_occ = {1'b0, r_f_cnt} + {2'b00, r_p_vld};
  assign w_room = w_occ < (3'd2 + {2'b00, w_pop});
  assign w_issue = (r_r_st == R_DATA) &&
    (r_r_iss != 27'd0) && w_room;

  assign w_tail_keep = (r_r_len6 == 6'd0) ? KEEP_ALL :
    (64'h1 << r_r_len6) - 64'h1;

  // Read state register.
  always_ff @(posedge aclk) begin
    if (sys_reset) r_r_st <= R_IDLE;
    else r_r_st <= w_r_nxt;
  end

  // Read next state: status follows the last beat's handshake.
  always_comb begin
    w_r_nxt = r_r_st;
    unique case (r_r_st)
      R_IDLE: begin
        if (w_rc_hs)
          w_r_nxt = w_rlen_z ? R_STS : R_DATA;
      end
      R_DATA: begin
        if (w_pop && w_o_last) w_r_nxt = R_STS;
      end
      R_STS: begin
        if (w_rs_hs) w_r_nxt = R_IDLE;
      end
      default: w_r_nxt = R_IDLE;
    endcase
  end

  // Read outputs; idle beat fields are forced to zero.
  always_comb begin
    bus.s_axis_read_cmd_ready = (r_r_st == R_IDLE);
    bus.m_axis_read_data_valid = w_o_vld;
    bus.m_axis_read_data_last = w_o_vld & w_o_last;
    bus.m_axis_read_data_data = w_o_vld ? w_o_data : '0;
    bus.m_axis_read_data_keep = '0;
    if (w_o_vld)
      bus.m_axis_read_data_keep =
        w_o_last ? w_tail_keep : KEEP_ALL;
    bus.m_axis_read_sts_valid = (r_r_st == R_STS);
    bus.m_axis_read_sts_data = 8'h00;
    if (r_r_st == R_STS)
      bus.m_axis_read_sts_data =
        r_r_err ? STS_ERR : STS_OK;
  end

  // Read issue counters and the BRAM output stage tags.
  always_ff @(posedge aclk) begin
    if (sys_reset) begin
      r_r_idx <= '0;
      r_r_iss <= '0;
      r_r_len6 <= '0;
      r_r_err <= 1'b0;
      r_p_vld <= 1'b0;
      r_p_last <= 1'b0;
    end else begin
      if (w_rc_hs) begin
        r_r_idx <= bus.s_axis_read_cmd_address[AW+5:6];
        r_r_iss <= f_beats(bus.s_axis_read_cmd_length);
        r_r_len6 <= bus.s_axis_read_cmd_length[5:0];
        r_r_err <= w_rlen_z;
      end else if (w_issue) begin
        r_r_idx <= r_r_idx + AW'(1);
        r_r_iss <= r_r_iss - 27'd1;
      end
      r_p_vld <= w_issue;
      if (w_issue) r_p_last <= (r_r_iss == 27'd1);
    end
  end

  // Skid FIFO pointers and occupancy.
  always_ff @(posedge aclk) begin
    if (sys_reset) begin
      r_f_wp <= 1'b0;
      r_f_rp <= 1'b0;
      r_f_cnt <= 2'd0;
    end else begin
      if (w_push) r_f_wp <= ~r_f_wp;
      if (w_fpop) r_f_rp <= ~r_f_rp;
      r_f_cnt <= r_f_cnt + {1'b0, w_push} -
        {1'b0, w_fpop};
    end
  end

  // Skid FIFO storage, loaded from the BRAM output stage.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_f_data[r_f_wp] <= r_bram_q;
      r_f_last[r_f_wp] <= r_p_last;
    end
  end

  // BRAM: byte-masked write port, read-first registered read port.
  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int b = 0; b < 64; b++) begin
        if (bus.s_axis_write_data_keep[b])
          r_mem[r_w_idx][b*8 +: 8] <=
            bus.s_axis_write_data_data[b*8 +: 8];
      end
    end
    if (w_issue) r_bram_q <= r_mem[r_r_idx];
  end

endmodule

// File: tb/tb_tcp_mem_responder.sv
// tb_tcp_mem_responder: randomized bench checking the responder
// against a word-level memory and status model.
module tb_tcp_mem_responder;
  localparam int D = 4096;

  logic aclk = 1'b0;
  logic sys_reset = 1'b1;
  int n_run = 0;
  int n_fail = 0;

  logic [511:0] m_mem [int];
  logic [63:0] m_known [int];

  tcp_mem_responder_if bus();

  tcp_mem_responder #(.MEM_DEPTH(D)) dut (
    .aclk(aclk),
    .sys_reset(sys_reset),
    .bus(bus)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [511:0] bmask(input logic [63:0] k);
    logic [511:0] m;
    for (int b = 0; b < 64; b++) m[b*8 +: 8] = {8{k[b]}};
    return m;
  endfunction

  function automatic int nbeats(input int len);
    return (len + 63) / 64;
  endfunction

  function automatic logic [63:0] tail_keep(input int len);
    logic [63:0] k;
    int r;
    k = '0;
    r = len % 64;
    if (r == 0) r = 64;
    for (int b = 0; b < r; b++) k[b] = 1'b1;
    return k;
  endfunction

  function automatic int widx(input logic [63:0] a, input int i);
    return int'((a / 64 + 64'(i)) % 64'(D));
  endfunction

  task automatic send_cmd(input bit rd, input logic [63:0] a,
                          input int len, input string tag);
    int n;
    n = 0;
    if (rd) begin
      bus.s_axis_read_cmd_address = a;
      bus.s_axis_read_cmd_length = 32'(len);
      bus.s_axis_read_cmd_valid = 1'b1;
    end else begin
      bus.s_axis_write_cmd_address = a;
      bus.s_axis_write_cmd_length = 32'(len);
      bus.s_axis_write_cmd_valid = 1'b1;
    end
    while (!(rd ? bus.s_axis_read_cmd_ready
                : bus.s_axis_write_cmd_ready) && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_cmd_to"}, n < 200, 1'b1);
    tick();
    bus.s_axis_read_cmd_valid = 1'b0;
    bus.s_axis_write_cmd_valid = 1'b0;
  endtask

  task automatic get_sts(input bit rd, input logic [7:0] exp,
                         input string tag);
    int n;
    int hold;
    n = 0;
    while (!(rd ? bus.m_axis_read_sts_valid
                : bus.m_axis_write_sts_valid) && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_sts_to"}, n < 200, 1'b1);
    hold = $urandom_range(0, 2);
    for (int h = 0; h <= hold; h++) begin
      chk({tag, "_sts"},
          rd ? {bus.m_axis_read_sts_valid, bus.m_axis_read_sts_data}
             : {bus.m_axis_write_sts_valid, bus.m_axis_write_sts_data},
          {1'b1, exp});
      if (h == hold) begin
        if (rd) bus.m_axis_read_sts_ready = 1'b1;
        else bus.m_axis_write_sts_ready = 1'b1;
      end
      tick();
    end
    bus.m_axis_read_sts_ready = 1'b0;
    bus.m_axis_write_sts_ready = 1'b0;
    chk({tag, "_next_cmd"},
        rd ? bus.s_axis_read_cmd_ready : bus.s_axis_write_cmd_ready,
        1'b1);
  endtask

  task automatic wr_txn(input logic [63:0] a, input int len,
                        input int nsend, input bit rkeep,
                        input string tag);
    int nb;
    int n;
    int idx;
    logic [511:0] d;
    logic [63:0] k;
    logic [7:0] es;
    nb = nbeats(len);
    if (len == 0) nsend = 0;
    send_cmd(1'b0, a, len, tag);
    chk({tag, "_dready"}, bus.s_axis_write_data_ready, len != 0);
    for (int i = 0; i < nsend; i++) begin
      d = rnd512();
      k = rkeep ? {$urandom, $urandom} : '1;
      bus.s_axis_write_data_data = d;
      bus.s_axis_write_data_keep = k;
      bus.s_axis_write_data_last = (i == nsend - 1);
      bus.s_axis_write_data_valid = 1'b1;
      n = 0;
      while (!bus.s_axis_write_data_ready && n < 50) begin
        tick();
        n++;
      end
      chk({tag, "_wd_to"}, n < 50, 1'b1);
      tick();
      if (i < nb) begin
        idx = widx(a, i);
        if (!m_mem.exists(idx)) begin
          m_mem[idx] = '0;
          m_known[idx] = '0;
        end
        m_mem[idx] = (m_mem[idx] & ~bmask(k)) | (d & bmask(k));
        m_known[idx] = m_known[idx] | k;
      end
    end
    bus.s_axis_write_data_valid = 1'b0;
    bus.s_axis_write_data_last = 1'b0;
    es = (len != 0 && nsend == nb) ? 8'h80 : 8'h01;
    chk({tag, "_sts_next"}, bus.m_axis_write_sts_valid, 1'b1);
    get_sts(1'b0, es, tag);
  endtask

  task automatic rd_txn(input logic [63:0] a, input int len,
                        input bit rnd, input int abort_at,
                        input string tag);
    int nb;
    int got;
    int cyc;
    int idx;
    bit seen;
    bit rdy;
    bit stalled;
    logic [511:0] ed;
    logic [511:0] m;
    logic [63:0] ek;
    nb = nbeats(len);
    got = 0;
    cyc = 1;
    seen = 1'b0;
    stalled = 1'b0;
    send_cmd(1'b1, a, len, tag);
    if (nb > 0)
      chk({tag, "_t1"}, bus.m_axis_read_data_valid, 1'b0);
    while (got < nb && cyc < 4000) begin
      if (abort_at > 0 && got == abort_at) break;
      rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.m_axis_read_data_ready = rdy;
      if (stalled)
        chk({tag, "_hold_v"}, bus.m_axis_read_data_valid, 1'b1);
      if (bus.m_axis_read_data_valid) begin
        idx = widx(a, got);
        m = m_known.exists(idx) ? bmask(m_known[idx]) : '0;
        ed = m_mem.exists(idx) ? m_mem[idx] : '0;
        ek = (got == nb - 1) ? tail_keep(len) : '1;
        if (!seen) begin
          seen = 1'b1;
          chk({tag, "_lat"}, cyc, 2);
        end
        chk({tag, "_data"}, bus.m_axis_read_data_data & m, ed & m);
        chk({tag, "_keep"}, bus.m_axis_read_data_keep, ek);
        chk({tag, "_last"}, bus.m_axis_read_data_last,
            got == nb - 1);
        if (rdy) got++;
        stalled = !rdy;
      end else begin
        stalled = 1'b0;
      end
      if (got == nb && !rnd) chk({tag, "_rate"}, cyc, nb + 1);
      tick();
      cyc++;
    end
    bus.m_axis_read_data_ready = 1'b0;
    if (abort_at > 0) return;
    chk({tag, "_beats"}, got, nb);
    chk({tag, "_sts_next"}, bus.m_axis_read_sts_valid, 1'b1);
    chk({tag, "_novalid"}, bus.m_axis_read_data_valid, 1'b0);
    get_sts(1'b1, (len == 0) ? 8'h01 : 8'h80, tag);
  endtask

  initial begin
    logic [63:0] a;
    int len;
    int nb;
    int ns;
    int r;
    bus.s_axis_write_cmd_valid = 1'b0;
    bus.s_axis_write_cmd_address = '0;
    bus.s_axis_write_cmd_length = '0;
    bus.s_axis_write_data_valid = 1'b0;
    bus.s_axis_write_data_last = 1'b0;
    bus.s_axis_write_data_data = '0;
    bus.s_axis_write_data_keep = '0;
    bus.m_axis_write_sts_ready = 1'b0;
    bus.s_axis_read_cmd_valid = 1'b0;
    bus.s_axis_read_cmd_address = '0;
    bus.s_axis_read_cmd_length = '0;
    bus.m_axis_read_data_ready = 1'b0;
    bus.m_axis_read_sts_ready = 1'b0;

    sys_reset = 1'b1;
    repeat (3) tick();
    sys_reset = 1'b0;
    chk("rst_wcmd_rdy", bus.s_axis_write_cmd_ready, 1'b1);
    chk("rst_rcmd_rdy", bus.s_axis_read_cmd_ready, 1'b1);
    chk("rst_wdata_rdy", bus.s_axis_write_data_ready, 1'b0);
    chk("rst_valids", {bus.m_axis_write_sts_valid,
                       bus.m_axis_read_data_valid,
                       bus.m_axis_read_sts_valid}, 3'b000);
    chk("rst_last", bus.m_axis_read_data_last, 1'b0);
    chk("rst_keep", bus.m_axis_read_data_keep, 64'h0);
    chk("rst_data", bus.m_axis_read_data_data, 512'h0);
    chk("rst_sts", {bus.m_axis_write_sts_data,
                    bus.m_axis_read_sts_data}, 16'h0);

    wr_txn(64'h0, 128, 2, 1'b0, "w128");
    rd_txn(64'h0, 128, 1'b0, 0, "r128");
    rd_txn(64'h0, 100, 1'b0, 0, "r100");

    wr_txn(64'(64 * 12), 64, 1, 1'b0, "wpre12");
    wr_txn(64'(64 * 10), 192, 2, 1'b0, "wearly");
    rd_txn(64'(64 * 10), 192, 1'b0, 0, "rearly");

    wr_txn(64'(64 * 21), 128, 2, 1'b0, "wpre21");
    wr_txn(64'(64 * 20), 64, 3, 1'b0, "wdrain");
    rd_txn(64'(64 * 20), 192, 1'b0, 0, "rdrain");

    wr_txn(64'((D - 1) * 64), 128, 2, 1'b0, "wwrap");
    rd_txn(64'((D - 1) * 64), 128, 1'b0, 0, "rwrap");

    wr_txn(64'(64 * 100), 4096, 64, 1'b1, "w64");
    rd_txn(64'(64 * 100), 4096, 1'b1, 0, "r64");

    wr_txn(64'h0, 0, 0, 1'b0, "wzero");
    rd_txn(64'h0, 0, 1'b0, 0, "rzero");

    wr_txn(64'(64 * 300), 1024, 16, 1'b0, "w16");
    rd_txn(64'(64 * 300), 1024, 1'b0, 5, "rabort");
    sys_reset = 1'b1;
    tick();
    chk("abort_valid", bus.m_axis_read_data_valid, 1'b0);
    chk("abort_sts", bus.m_axis_read_sts_valid, 1'b0);
    chk("abort_cmd_rdy", bus.s_axis_read_cmd_ready, 1'b1);
    sys_reset = 1'b0;
    rd_txn(64'(64 * 300), 1024, 1'b0, 0, "rpost");
    rd_txn(64'h0, 128, 1'b0, 0, "rpost0");

    for (int t = 0; t < 40; t++) begin
      a = 64'($urandom_range(0, 40) + ((t % 4 == 0) ? D - 8 : 0));
      a = a * 64 + 64'($urandom_range(0, 63));
      len = ($urandom_range(0, 5) == 0) ? 0
          : int'($urandom_range(1, 700));
      if ($urandom_range(0, 1) == 1) begin
        nb = nbeats(len);
        r = $urandom_range(0, 5);
        ns = nb;
        if (r == 0 && nb > 1) ns = nb - 1;
        if (r == 1) ns = nb + 1;
        wr_txn(a, len, ns, 1'b1, "wrnd");
      end else begin
        rd_txn(a, len, 1'b1, 0, "rrnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
